// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative RV32M execute unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
//
// Does one radix-2 step per cycle on operand magnitudes, then applies a sign
// fixup on the last step. Divide-by-zero and signed overflow skip the
// iteration and finish on the accepting edge.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     request from EX (mul_en | div_en)
//   funct3    RV32M op select
//   rs1_data  operand A / dividend
//   rs2_data  operand B / divisor
//   kill      EX flush; aborts a calculation, wins over start
//   m_out     registered result, held until the next completion
//   done      one-cycle pulse while in DONE
//   ready     low only while calculating (pure state decode)
module muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int STEP_CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            kill,
  output logic [XLEN-1:0] m_out,
  output logic            done,
  output logic            ready
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_e;

  // Per-request context captured on acceptance.
  typedef struct packed {
    logic [2:0] f3;
    logic       neg;   // negate product / quotient
    logic       rneg;  // negate remainder (dividend sign)
  } ctx_t;

  localparam logic [XLEN-1:0]       MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]       ALL_ONES = '1;
  localparam logic [STEP_CNT_W-1:0] CNT_LAST = STEP_CNT_W'(XLEN-1);

  state_e                state_q, state_d;
  logic [STEP_CNT_W-1:0] cnt_q, cnt_d;
  ctx_t                  ctx_q, ctx_d;
  logic [XLEN-1:0]       opa_q, opa_d;   // multiplicand or divisor magnitude
  logic [XLEN-1:0]       acc_q, acc_d;   // product high half or partial remainder
  logic [XLEN-1:0]       lo_q, lo_d;     // multiplier/product low, or dividend/quotient
  logic [XLEN-1:0]       m_out_q, m_out_d;

  // ---------------------------------------------------------------------------
  // Request decode (only consumed on the accepting edge)
  // ---------------------------------------------------------------------------
  logic            req_div, a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, fast;
  logic [XLEN-1:0] fast_res;

  always_comb begin
    req_div  = funct3[2];
    // Signed rs1: MUL, MULH, MULHSU, DIV, REM. Signed rs2: MUL, MULH, DIV, REM.
    a_sgn    = req_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
    b_sgn    = req_div ? ~funct3[0] : ~funct3[1];
    a_neg    = a_sgn & rs1_data[XLEN-1];
    b_neg    = b_sgn & rs2_data[XLEN-1];
    a_mag    = a_neg ? -rs1_data : rs1_data;
    b_mag    = b_neg ? -rs2_data : rs2_data;
    div_zero = req_div & (rs2_data == '0);
    div_ovf  = req_div & ~funct3[0] & (rs1_data == MIN_NEG) & (rs2_data == ALL_ONES);
    fast     = div_zero | div_ovf;
    // funct3[1] selects remainder within the divide group.
    if (div_zero) fast_res = funct3[1] ? rs1_data : ALL_ONES;
    else          fast_res = funct3[1] ? '0       : MIN_NEG;
  end

  // ---------------------------------------------------------------------------
  // One iteration step
  // ---------------------------------------------------------------------------
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic              div_ge;
  logic [XLEN-1:0]   step_acc, step_lo;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quot, rem, final_res;

  always_comb begin
    // Shift-add, LSB first: add multiplicand when the multiplier bit is set,
    // then shift {carry, acc, lo} right so product bits fall into lo.
    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opa_q} : '0);
    // Restoring divide: bring the next dividend bit into the remainder and
    // subtract the divisor if it fits. Shifted remainder can need XLEN+1 bits.
    div_shift = {acc_q, lo_q[XLEN-1]};
    div_ge    = div_shift >= {1'b0, opa_q};
    div_diff  = div_shift - {1'b0, opa_q};

    if (ctx_q.f3[2]) begin
      step_acc = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
      step_lo  = {lo_q[XLEN-2:0], div_ge};
    end else begin
      step_acc = mul_sum[XLEN:1];
      step_lo  = {mul_sum[0], lo_q[XLEN-1:1]};
    end

    prod     = {step_acc, step_lo};
    prod_fix = ctx_q.neg  ? -prod     : prod;
    quot     = ctx_q.neg  ? -step_lo  : step_lo;
    rem      = ctx_q.rneg ? -step_acc : step_acc;

    if (ctx_q.f3[2])               final_res = ctx_q.f3[1] ? rem : quot;
    else if (ctx_q.f3[1:0] == '0)  final_res = prod_fix[XLEN-1:0];
    else                           final_res = prod_fix[2*XLEN-1:XLEN];
  end

  // ---------------------------------------------------------------------------
  // Next-state / datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctx_d   = ctx_q;
    opa_d   = opa_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    m_out_d = m_out_q;

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start && !kill) begin
          ctx_d.f3 = funct3;
          if (fast) begin
            m_out_d = fast_res;
            state_d = DONE;
          end else begin
            ctx_d.neg  = a_neg ^ b_neg;
            ctx_d.rneg = a_neg;
            opa_d      = req_div ? b_mag : a_mag;
            lo_d       = req_div ? a_mag : b_mag;
            acc_d      = '0;
            cnt_d      = CNT_LAST;
            state_d    = CALC;
          end
        end
      end
      CALC: begin
        if (kill) begin
          state_d = IDLE;
        end else begin
          acc_d = step_acc;
          lo_d  = step_lo;
          if (cnt_q == '0) begin
            m_out_d = final_res;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ctx_q   <= '0;
      opa_q   <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      m_out_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctx_q   <= ctx_d;
      opa_q   <= opa_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      m_out_q <= m_out_d;
    end
  end

  assign m_out = m_out_q;
  assign done  = (state_q == DONE);
  assign ready = (state_q != CALC);

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data;
  logic        kill;
  logic [31:0] m_out;
  logic        done, ready;

  int n_chk  = 0;
  int n_fail = 0;

  muldiv_unit #(.XLEN(32), .STEP_CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .kill(kill),
    .m_out(m_out), .done(done), .ready(ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a, b, exp;
    int          lat;
  } vec_t;

  localparam int NV = 16;
  vec_t vt[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic plus the RV32M special cases.
  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int          ia, ib;
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    logic        ovf;
    ia = a; ib = b; sa = ia; sb = ib;
    ua = 0; ua[31:0] = a;
    ub = 0; ub[31:0] = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p = 64'(sa * sb);
    case (f3)
      3'd0: return p[31:0];
      3'd1: return p[63:32];
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf)    return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf)    return 32'h0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 0)) return 0;
    if (f3[2] && !f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return 32;
  endfunction

  function automatic vec_t mkv(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp, input int lat);
    vec_t v;
    v.f3 = f3; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
    return v;
  endfunction

  // Called at #1 after the accepting edge; counts edges until done.
  task automatic wait_done(output int lat, output bit rdy_ok);
    lat = 0; rdy_ok = 1'b1;
    while (!done && lat < 40) begin
      if (ready) rdy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Issue one op from IDLE; returns at #1 into the DONE cycle (or on timeout).
  // Operands are scrambled after acceptance since the unit must not need them.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output bit rdy_ok);
    start = 1'b1; funct3 = f3; rs1_data = a; rs2_data = b;
    @(posedge clk); #1;
    start = 1'b0; funct3 = 3'($urandom); rs1_data = $urandom; rs2_data = $urandom;
    wait_done(lat, rdy_ok);
    res = m_out;
  endtask

  task automatic check_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    logic [31:0] res;
    int          lat;
    bit          rdy_ok;
    run_op(f3, a, b, res, lat, rdy_ok);
    chk({tag, " result"}, res, exp);
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " ready low in calc"}, 32'(rdy_ok), 32'd1);
    chk({tag, " ready at done"}, 32'(ready), 32'd1);
    @(posedge clk); #1;
    chk({tag, " done one pulse"}, 32'(done), 32'd0);
    chk({tag, " m_out held"}, m_out, exp);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b, res;
    int          lat;
    bit          rdy_ok;

    vt[0]  = mkv(3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 32);
    vt[1]  = mkv(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32);
    vt[2]  = mkv(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32);
    vt[3]  = mkv(3'd2, 32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFF, 32);
    vt[4]  = mkv(3'd4, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 32);
    vt[5]  = mkv(3'd6, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32);
    vt[6]  = mkv(3'd5, 32'd100,        32'd7,          32'd14,        32);
    vt[7]  = mkv(3'd7, 32'd100,        32'd7,          32'd2,         32);
    vt[8]  = mkv(3'd5, 32'd5,          32'd0,          32'hFFFF_FFFF, 0);
    vt[9]  = mkv(3'd6, 32'd5,          32'd0,          32'd5,         0);
    vt[10] = mkv(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    vt[11] = mkv(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         0);
    vt[12] = mkv(3'd4, 32'd5,          32'd0,          32'hFFFF_FFFF, 0);
    vt[13] = mkv(3'd7, 32'd5,          32'd0,          32'd5,         0);
    vt[14] = mkv(3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32);
    vt[15] = mkv(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32);

    rst_n = 1'b0; start = 1'b0; kill = 1'b0; funct3 = '0; rs1_data = '0; rs2_data = '0;
    #12;
    chk("reset ready", 32'(ready), 32'd1);
    chk("reset done", 32'(done), 32'd0);
    chk("reset m_out", m_out, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++)
      check_op($sformatf("vec%0d", i), vt[i].f3, vt[i].a, vt[i].b, vt[i].exp, vt[i].lat);

    // Kill mid-CALC: abort, no done, previous result (DIVU 100/7 = 14) kept.
    check_op("pre-kill", 3'd5, 32'd100, 32'd7, 32'd14, 32);
    start = 1'b1; funct3 = 3'd4; rs1_data = 32'd1000; rs2_data = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kill calc ready", 32'(ready), 32'd1);
    chk("kill calc done", 32'(done), 32'd0);
    chk("kill calc m_out", m_out, 32'd14);
    check_op("post-kill mul", 3'd0, 32'd3, 32'd4, 32'd12, 32);

    // Kill in DONE: done still seen, the concurrent start (a fast op) is refused.
    run_op(3'd0, 32'd6, 32'd7, res, lat, rdy_ok);
    chk("kdone result", res, 32'd42);
    chk("kdone done visible", 32'(done), 32'd1);
    kill = 1'b1; start = 1'b1; funct3 = 3'd5; rs1_data = 32'd5; rs2_data = 32'd0;
    @(posedge clk); #1;
    kill = 1'b0; start = 1'b0;
    chk("kdone ready", 32'(ready), 32'd1);
    chk("kdone no done", 32'(done), 32'd0);
    chk("kdone m_out", m_out, 32'd42);

    // Back-to-back: start held through CALC (ignored) and taken again in DONE.
    start = 1'b1; funct3 = 3'd0; rs1_data = 32'd9; rs2_data = 32'd9;
    @(posedge clk); #1;
    rs1_data = 32'd2; rs2_data = 32'd5;
    wait_done(lat, rdy_ok);
    chk("b2b first result", m_out, 32'd81);
    chk("b2b first latency", 32'(lat), 32'd32);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b no idle gap", 32'(ready), 32'd0);
    wait_done(lat, rdy_ok);
    chk("b2b second result", m_out, 32'd10);
    chk("b2b second latency", 32'(lat), 32'd32);
    chk("b2b ready low", 32'(rdy_ok), 32'd1);
    @(posedge clk); #1;

    // Asynchronous reset mid-CALC.
    start = 1'b1; funct3 = 3'd0; rs1_data = 32'd5; rs2_data = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midreset ready", 32'(ready), 32'd1);
    chk("midreset done", 32'(done), 32'd0);
    chk("midreset m_out", m_out, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("postreset no done", 32'(done), 32'd0);
    check_op("postreset op", 3'd7, 32'd100, 32'd9, 32'd1, 32);

    // Randomized ops against the reference model.
    for (int i = 0; i < 48; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 20); b = $urandom_range(1, 20); end
        3: a = 32'h8000_0000;
        4: b = 32'($urandom_range(1, 300)) | 32'hFFFF_F000;
        default: ;
      endcase
      check_op($sformatf("rnd%0d f3=%0d a=%h b=%h", i, f3, a, b), f3, a, b,
               ref_md(f3, a, b), ref_lat(f3, a, b));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
